// File: rtl/ov7670_config_seq_if.sv
// Request/response bus between the configuration sequencer and the I2C master.
// The sequencer uses the master modport; the I2C master (or its model) uses slave.
interface ov7670_config_seq_if;
    logic       wr;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       nack;

    modport master (output wr, slave_addr, reg_addr, wdata, input busy, nack);
    modport slave  (input wr, slave_addr, reg_addr, wdata, output busy, nack);
endinterface

// File: rtl/ov7670_config_seq.sv
// Walks the camera register-initialisation ROM and issues one I2C write per
// entry, with NACK retries, millisecond delay entries and an end-of-table marker.
module ov7670_config_seq #(
    parameter logic [6:0] SLAVE_ADDR = 7'h21,
    parameter int         ROM_AW     = 8,
    parameter int         CLK_PER_MS = 100000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    ov7670_config_seq_if.master i2c,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ROM_AW-1:0] o_err_index
);
    // 255 ms worst case must fit: 8 bits of nn plus the bits of CLK_PER_MS.
    localparam int DW = 8 + $clog2(CLK_PER_MS);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [15:0]       END_MARK  = 16'hFFFF;
    localparam logic [7:0]        DELAY_TAG = 8'hF0;
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_CHECK,
        S_DELAY,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] delay_cnt;
    logic [RW-1:0] retry_cnt;
    logic          nack_latch;

    assign i2c.slave_addr = SLAVE_ADDR;

    // NOTE: every register here is updated with <= so all next-state values are
    // computed from the same pre-edge snapshot, regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            delay_cnt    <= '0;
            retry_cnt    <= '0;
            nack_latch   <= 1'b0;
            o_rom_addr   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_index  <= '0;
            i2c.wr       <= 1'b0;
            i2c.reg_addr <= '0;
            i2c.wdata    <= '0;
        end else begin
            i2c.wr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_error     <= 1'b0;
                        o_err_index <= '0;
                        retry_cnt   <= '0;
                        o_rom_addr  <= '0;
                        o_busy      <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (i_rom_data == END_MARK) begin
                        state <= S_DONE;
                    end else if (i_rom_data[15:8] == DELAY_TAG) begin
                        delay_cnt <= DW'(i_rom_data[7:0]) * DW'(CLK_PER_MS);
                        state     <= S_DELAY;
                    end else begin
                        i2c.reg_addr <= i_rom_data[15:8];
                        i2c.wdata    <= i_rom_data[7:0];
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!i2c.busy) begin
                        i2c.wr     <= 1'b1;
                        nack_latch <= 1'b0;
                        state      <= S_WAIT_ACC;
                    end
                end
                S_WAIT_ACC: begin
                    if (i2c.busy) begin
                        nack_latch <= nack_latch | i2c.nack;
                        state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // The master drops its NACK flags together with busy, so
                    // the outcome is only visible while busy is still high.
                    if (i2c.busy) nack_latch <= nack_latch | i2c.nack;
                    else          state      <= S_CHECK;
                end
                S_CHECK: begin
                    if (!nack_latch) begin
                        retry_cnt <= '0;
                        if (o_rom_addr == LAST_ADDR) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            o_rom_addr <= o_rom_addr + ROM_AW'(1);
                            state      <= S_FETCH;
                        end
                    end else if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= S_ISSUE;
                    end else begin
                        o_error     <= 1'b1;
                        o_err_index <= o_rom_addr;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == '0) begin
                        // Running off the end of the table counts as completion.
                        if (o_rom_addr == LAST_ADDR) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            o_rom_addr <= o_rom_addr + ROM_AW'(1);
                            state      <= S_FETCH;
                        end
                    end else begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_config_seq.sv
// Self-checking bench: ROM and I2C master models, table-level reference model,
// directed scenarios plus randomized tables with random NACK patterns.
module tb_ov7670_config_seq;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int CPM   = 10;
    localparam int MR    = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] err_index;
    logic [15:0]   rom_data = 16'h0;
    logic          o_busy, o_done, o_error;

    ov7670_config_seq_if ifc();

    ov7670_config_seq #(
        .SLAVE_ADDR(7'h21), .ROM_AW(AW), .CLK_PER_MS(CPM), .MAX_RETRY(MR)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .i2c(ifc.master),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_index(err_index)
    );

    initial forever #5 clk = ~clk;

    logic [15:0] rom [DEPTH];
    int          nack_n   [DEPTH];
    int          attempts [DEPTH];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        exp_done, exp_err;
    logic [AW-1:0] exp_idx, exp_addr;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, first_wr_cyc = -1, wr_while_busy = 0;
    bit hold_busy = 1'b0;
    int acc_wait = 0, busy_left = 0;
    bit pend_nack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // I2C master model: accepts a write, goes busy after 1-3 cycles for 2-6
    // cycles, reports NACK while busy and clears it as busy falls.
    initial begin
        ifc.busy = 1'b0;
        ifc.nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                acc_wait = 0; busy_left = 0; ifc.busy = 1'b0; ifc.nack = 1'b0;
                continue;
            end
            if (ifc.wr === 1'b1) begin
                if (ifc.busy) wr_while_busy++;
                if (got_q.size() == 0) first_wr_cyc = cyc;
                got_q.push_back({ifc.reg_addr, ifc.wdata});
                pend_nack = attempts[rom_addr] < nack_n[rom_addr];
                attempts[rom_addr]++;
                acc_wait = $urandom_range(1, 3);
            end
            if (acc_wait > 0) begin
                acc_wait--;
                if (acc_wait == 0) busy_left = $urandom_range(2, 6);
            end else if (busy_left > 0) begin
                busy_left--;
            end
            ifc.busy = hold_busy || (busy_left > 0);
            ifc.nack = (busy_left > 0) && pend_nack;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: walk the table by its rules and list the writes the camera sees.
    task automatic model();
        int nwr;
        exp_q.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_idx = '0; exp_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_addr = AW'(i);
            if (rom[i] == 16'hFFFF) begin exp_done = 1'b1; return; end
            if (rom[i][15:8] == 8'hF0) continue;
            nwr = (nack_n[i] > MR) ? MR + 1 : nack_n[i] + 1;
            repeat (nwr) exp_q.push_back(rom[i]);
            if (nack_n[i] > MR) begin exp_err = 1'b1; exp_idx = AW'(i); return; end
        end
        exp_done = 1'b1;
    endtask

    task automatic clear_tab();
        for (int i = 0; i < DEPTH; i++) begin rom[i] = 16'hFFFF; nack_n[i] = 0; end
    endtask

    task automatic clear_log();
        for (int i = 0; i < DEPTH; i++) attempts[i] = 0;
        got_q.delete();
        wr_while_busy = 0;
        first_wr_cyc = -1;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; start_cyc = cyc;
    endtask

    task automatic wait_idle(input string name, input bit poke);
        int n = 0;
        while (o_busy !== 1'b0 && n < 5000) begin
            @(negedge clk); n++;
            start = (poke && n == 20 && o_busy === 1'b1);
        end
        start = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL %s timeout: busy=%b after %0d cycles, want 0", name, o_busy, n);
        end
    endtask

    task automatic check_results(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s wr_count: got %0d, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL %s write[%0d]: got %h, want %h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({o_done, o_error, o_busy} !== {exp_done, exp_err, 1'b0}) begin
            errors++; $display("FAIL %s status: done/err/busy got %b%b%b, want %b%b0",
                               name, o_done, o_error, o_busy, exp_done, exp_err);
        end
        checks++;
        if (err_index !== exp_idx) begin
            errors++; $display("FAIL %s err_index: got %0d, want %0d", name, err_index, exp_idx);
        end
        checks++;
        if (rom_addr !== exp_addr) begin
            errors++; $display("FAIL %s rom_addr: got %0d, want %0d", name, rom_addr, exp_addr);
        end
        checks++;
        if (wr_while_busy != 0) begin
            errors++; $display("FAIL %s wr_while_busy: got %0d, want 0", name, wr_while_busy);
        end
    endtask

    task automatic run_and_check(input string name, input bit poke);
        model();
        clear_log();
        start_pulse();
        wait_idle(name, poke);
        check_results(name);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        checks++;
        if ({ifc.wr, ifc.reg_addr, ifc.wdata, rom_addr, o_busy, o_done, o_error, err_index} !== '0) begin
            errors++; $display("FAIL reset outputs: got wr=%b reg=%h dat=%h addr=%0d busy=%b done=%b err=%b idx=%0d, want all 0",
                               ifc.wr, ifc.reg_addr, ifc.wdata, rom_addr, o_busy, o_done, o_error, err_index);
        end
        checks++;
        if (ifc.slave_addr !== 7'h21) begin
            errors++; $display("FAIL reset slave_addr: got %h, want 21", ifc.slave_addr);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        clear_tab();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run_and_check("basic", 1'b0);
    endtask

    task automatic test_delay();
        clear_tab();
        rom[0] = 16'hF003; rom[1] = 16'h3A04;
        run_and_check("delay", 1'b0);
        checks++;
        if (first_wr_cyc < 0 || first_wr_cyc - start_cyc < 31) begin
            errors++; $display("FAIL delay latency: first wr %0d cycles after start, want >= 31",
                               first_wr_cyc - start_cyc);
        end
    endtask

    task automatic test_nack_retry();
        clear_tab();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h0C04;
        nack_n[1] = 2;
        run_and_check("nack_retry", 1'b0);
        clear_tab();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h0C04;
        nack_n[1] = MR;
        run_and_check("nack_max", 1'b0);
    endtask

    task automatic test_nack_fail();
        clear_tab();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h0C04;
        nack_n[1] = 99;
        run_and_check("nack_fail", 1'b0);
    endtask

    task automatic test_busy_hold();
        int rel_cyc;
        clear_tab();
        rom[0] = 16'h1280;
        model();
        clear_log();
        @(negedge clk); hold_busy = 1'b1;
        @(negedge clk);
        start_pulse();
        repeat (50) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL busy_hold early_wr: got %0d writes, want 0", got_q.size());
        end
        hold_busy = 1'b0;
        rel_cyc = cyc + 1;
        wait_idle("busy_hold", 1'b0);
        check_results("busy_hold");
        checks++;
        if (first_wr_cyc < 0 || first_wr_cyc - rel_cyc > 1 || first_wr_cyc - rel_cyc < 1) begin
            errors++; $display("FAIL busy_hold wr_latency: got %0d cycles after busy fell, want 1",
                               first_wr_cyc - rel_cyc);
        end
    endtask

    task automatic test_wrap();
        clear_tab();
        for (int i = 0; i < DEPTH; i++) rom[i] = {8'(i + 8'h20), 8'(i * 3)};
        run_and_check("wrap", 1'b0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_tab();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        clear_log();
        start_pulse();
        while (!(got_q.size() >= 1 && ifc.busy === 1'b1) && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({ifc.wr, ifc.reg_addr, ifc.wdata, rom_addr, o_busy, o_done, o_error, err_index} !== '0
            || ifc.slave_addr !== 7'h21 || n >= 1000) begin
            errors++; $display("FAIL reset_mid outputs: got reg=%h dat=%h addr=%0d busy=%b done=%b (waited %0d), want all 0",
                               ifc.reg_addr, ifc.wdata, rom_addr, o_busy, o_done, n);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        run_and_check("reset_restart", 1'b0);
    endtask

    task automatic test_random();
        int len, r;
        for (int it = 0; it < 10; it++) begin
            clear_tab();
            len = $urandom_range(3, DEPTH - 1);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7) rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
                else       rom[i] = {8'hF0, 8'($urandom_range(0, 2))};
                r = $urandom_range(0, 9);
                nack_n[i] = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, MR) : MR + 2;
            end
            run_and_check($sformatf("random%0d", it), it[0]);
        end
    endtask

    initial begin
        clear_tab();
        test_reset();
        test_basic();
        test_delay();
        test_nack_retry();
        test_nack_fail();
        test_busy_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
